// File: rtl/hdmi_avi_pkg.sv
// Shared constants, state encoding and field bundle for HDMI AVI InfoFrame handling.
package hdmi_avi_pkg;

  localparam logic [7:0] AVI_TYPE       = 8'h82;
  localparam logic [7:0] AVI_VERSION    = 8'h02;
  localparam logic [4:0] AVI_LENGTH     = 5'd13;
  localparam logic [4:0] LAST_SUM_INDEX = 5'd16;
  localparam logic [4:0] LAST_INDEX     = 5'd30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECEIVE,
    ST_CHECK
  } avi_state_t;

  typedef struct packed {
    logic [1:0]  video_format;
    logic        active_format_info_present;
    logic [1:0]  bar_info;
    logic [1:0]  scan_info;
    logic [1:0]  colorimetry;
    logic [1:0]  picture_aspect_ratio;
    logic [3:0]  active_format_aspect_ratio;
    logic        it_content;
    logic [2:0]  extended_colorimetry;
    logic [1:0]  rgb_quantization_range;
    logic [1:0]  non_uniform_picture_scaling;
    logic [6:0]  video_id_code;
    logic [1:0]  ycc_quantization_range;
    logic [1:0]  content_type;
    logic [3:0]  pixel_repetition;
    logic [15:0] bar_top_end;
    logic [15:0] bar_bottom_start;
    logic [15:0] bar_left_end;
    logic [15:0] bar_right_start;
  } avi_fields_t;

endpackage

// File: rtl/infoframe_checksum.sv
// Running modulo-256 InfoFrame byte sum; a frame is intact when the sum over all covered bytes is zero.
module infoframe_checksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic       acc,
  input  logic [7:0] data,
  output logic       sum_zero
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (load) begin
      sum_d = data;
    end else if (acc) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_zero = (sum_q == 8'd0);

endmodule

// File: rtl/avi_info_frame_receiver.sv
// Parses depacketized AVI InfoFrames (HB0..PB27), validates header and checksum,
// and holds the last good frame's fields with an optional staleness timeout.
module avi_info_frame_receiver
  import hdmi_avi_pkg::*;
#(
  parameter int STALE_TIMEOUT = 0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        packet_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        info_valid,
  output logic        frame_update,
  output logic        error_format,
  output logic        error_checksum,
  output logic        error_truncated,
  output logic [1:0]  video_format,
  output logic        active_format_info_present,
  output logic [1:0]  bar_info,
  output logic [1:0]  scan_info,
  output logic [1:0]  colorimetry,
  output logic [1:0]  picture_aspect_ratio,
  output logic [3:0]  active_format_aspect_ratio,
  output logic        it_content,
  output logic [2:0]  extended_colorimetry,
  output logic [1:0]  rgb_quantization_range,
  output logic [1:0]  non_uniform_picture_scaling,
  output logic [6:0]  video_id_code,
  output logic [1:0]  ycc_quantization_range,
  output logic [1:0]  content_type,
  output logic [3:0]  pixel_repetition,
  output logic [15:0] bar_top_end,
  output logic [15:0] bar_bottom_start,
  output logic [15:0] bar_left_end,
  output logic [15:0] bar_right_start
);

  localparam logic [31:0] STALE_LIMIT = 32'(STALE_TIMEOUT);

  avi_state_t  state_q, state_d;
  logic [4:0]  index_q, index_d;
  avi_fields_t fields_q, fields_d;
  logic        valid_q, valid_d;
  logic [31:0] stale_q, stale_d;
  logic        upd_q, upd_d, fmt_q, fmt_d, csum_q, csum_d, trunc_q, trunc_d;

  // Only HB0..PB13 are retained; PB14..PB27 carry nothing we decode.
  logic [7:0]  shadow_q [0:16];
  logic        shadow_we;
  logic [4:0]  shadow_addr;

  logic        sum_clear, sum_load, sum_acc, sum_zero;
  logic        hdr_bad;

  infoframe_checksum u_checksum (
    .clk      (clk_pixel),
    .reset    (reset),
    .clear    (sum_clear),
    .load     (sum_load),
    .acc      (sum_acc),
    .data     (byte_in),
    .sum_zero (sum_zero)
  );

  assign hdr_bad     = (shadow_q[1] != AVI_VERSION) || (shadow_q[2][4:0] != AVI_LENGTH);
  assign shadow_addr = packet_start ? 5'd0 : index_q;
  assign sum_clear   = (state_q == ST_CHECK);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    fields_d  = fields_q;
    valid_d   = valid_q;
    stale_d   = stale_q;
    upd_d     = 1'b0;
    fmt_d     = 1'b0;
    csum_d    = 1'b0;
    trunc_d   = 1'b0;
    sum_load  = 1'b0;
    sum_acc   = 1'b0;
    shadow_we = 1'b0;

    if (STALE_TIMEOUT > 0 && valid_q) begin
      if (stale_q != STALE_LIMIT) stale_d = stale_q + 32'd1;
      if (stale_q + 32'd1 == STALE_LIMIT) valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && packet_start) begin
          state_d   = ST_RECEIVE;
          index_d   = 5'd1;
          sum_load  = 1'b1;
          shadow_we = 1'b1;
        end
      end
      ST_RECEIVE: begin
        if (byte_valid) begin
          if (packet_start) begin
            trunc_d   = 1'b1;
            index_d   = 5'd1;
            sum_load  = 1'b1;
            shadow_we = 1'b1;
          end else begin
            if (index_q <= LAST_SUM_INDEX) begin
              sum_acc   = 1'b1;
              shadow_we = 1'b1;
            end
            if (index_q == LAST_INDEX) state_d = ST_CHECK;
            else                       index_d = index_q + 5'd1;
          end
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        index_d = '0;
        // Non-AVI packets share the stream and are dropped without comment.
        if (shadow_q[0] != AVI_TYPE) begin
          fmt_d = 1'b0;
        end else if (hdr_bad) begin
          fmt_d = 1'b1;
        end else if (!sum_zero) begin
          csum_d = 1'b1;
        end else begin
          fields_d.video_format                = shadow_q[4][6:5];
          fields_d.active_format_info_present  = shadow_q[4][4];
          fields_d.bar_info                    = shadow_q[4][3:2];
          fields_d.scan_info                   = shadow_q[4][1:0];
          fields_d.colorimetry                 = shadow_q[5][7:6];
          fields_d.picture_aspect_ratio        = shadow_q[5][5:4];
          fields_d.active_format_aspect_ratio  = shadow_q[5][3:0];
          fields_d.it_content                  = shadow_q[6][7];
          fields_d.extended_colorimetry        = shadow_q[6][6:4];
          fields_d.rgb_quantization_range      = shadow_q[6][3:2];
          fields_d.non_uniform_picture_scaling = shadow_q[6][1:0];
          fields_d.video_id_code               = shadow_q[7][6:0];
          fields_d.ycc_quantization_range      = shadow_q[8][7:6];
          fields_d.content_type                = shadow_q[8][5:4];
          fields_d.pixel_repetition            = shadow_q[8][3:0];
          fields_d.bar_top_end                 = {shadow_q[10], shadow_q[9]};
          fields_d.bar_bottom_start            = {shadow_q[12], shadow_q[11]};
          fields_d.bar_left_end                = {shadow_q[14], shadow_q[13]};
          fields_d.bar_right_start             = {shadow_q[16], shadow_q[15]};
          valid_d = 1'b1;
          stale_d = '0;
          upd_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
      stale_q  <= '0;
      upd_q    <= 1'b0;
      fmt_q    <= 1'b0;
      csum_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      fields_q <= fields_d;
      valid_q  <= valid_d;
      stale_q  <= stale_d;
      upd_q    <= upd_d;
      fmt_q    <= fmt_d;
      csum_q   <= csum_d;
      trunc_q  <= trunc_d;
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (shadow_we) shadow_q[shadow_addr] <= byte_in;
  end

  assign info_valid                  = valid_q;
  assign frame_update                = upd_q;
  assign error_format                = fmt_q;
  assign error_checksum              = csum_q;
  assign error_truncated             = trunc_q;
  assign video_format                = fields_q.video_format;
  assign active_format_info_present  = fields_q.active_format_info_present;
  assign bar_info                    = fields_q.bar_info;
  assign scan_info                   = fields_q.scan_info;
  assign colorimetry                 = fields_q.colorimetry;
  assign picture_aspect_ratio        = fields_q.picture_aspect_ratio;
  assign active_format_aspect_ratio  = fields_q.active_format_aspect_ratio;
  assign it_content                  = fields_q.it_content;
  assign extended_colorimetry        = fields_q.extended_colorimetry;
  assign rgb_quantization_range      = fields_q.rgb_quantization_range;
  assign non_uniform_picture_scaling = fields_q.non_uniform_picture_scaling;
  assign video_id_code               = fields_q.video_id_code;
  assign ycc_quantization_range      = fields_q.ycc_quantization_range;
  assign content_type                = fields_q.content_type;
  assign pixel_repetition            = fields_q.pixel_repetition;
  assign bar_top_end                 = fields_q.bar_top_end;
  assign bar_bottom_start            = fields_q.bar_bottom_start;
  assign bar_left_end                = fields_q.bar_left_end;
  assign bar_right_start             = fields_q.bar_right_start;

endmodule

// File: tb/tb_avi_info_frame_receiver.sv
// Self-checking bench: directed scenarios plus randomized frames against a byte-level reference model.
`timescale 1ns/1ps
module tb_avi_info_frame_receiver;

  localparam int TIMEOUT = 100;

  logic        clk_pixel = 1'b0;
  logic        reset = 1'b1;
  logic        packet_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        info_valid, frame_update, error_format, error_checksum, error_truncated;
  logic [1:0]  video_format, bar_info, scan_info, colorimetry, picture_aspect_ratio;
  logic [1:0]  rgb_quantization_range, non_uniform_picture_scaling, ycc_quantization_range, content_type;
  logic        active_format_info_present, it_content;
  logic [3:0]  active_format_aspect_ratio, pixel_repetition;
  logic [2:0]  extended_colorimetry;
  logic [6:0]  video_id_code;
  logic [15:0] bar_top_end, bar_bottom_start, bar_left_end, bar_right_start;

  avi_info_frame_receiver #(.STALE_TIMEOUT(TIMEOUT)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .packet_start(packet_start),
    .byte_valid(byte_valid), .byte_in(byte_in),
    .info_valid(info_valid), .frame_update(frame_update), .error_format(error_format),
    .error_checksum(error_checksum), .error_truncated(error_truncated),
    .video_format(video_format), .active_format_info_present(active_format_info_present),
    .bar_info(bar_info), .scan_info(scan_info), .colorimetry(colorimetry),
    .picture_aspect_ratio(picture_aspect_ratio), .active_format_aspect_ratio(active_format_aspect_ratio),
    .it_content(it_content), .extended_colorimetry(extended_colorimetry),
    .rgb_quantization_range(rgb_quantization_range), .non_uniform_picture_scaling(non_uniform_picture_scaling),
    .video_id_code(video_id_code), .ycc_quantization_range(ycc_quantization_range),
    .content_type(content_type), .pixel_repetition(pixel_repetition),
    .bar_top_end(bar_top_end), .bar_bottom_start(bar_bottom_start),
    .bar_left_end(bar_left_end), .bar_right_start(bar_right_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cnt_upd = 0, cnt_fmt = 0, cnt_csum = 0, cnt_trunc = 0;

  always @(posedge clk_pixel) cyc = cyc + 1;

  always @(negedge clk_pixel) begin
    if (!reset) begin
      if (frame_update)    cnt_upd++;
      if (error_format)    cnt_fmt++;
      if (error_checksum)  cnt_csum++;
      if (error_truncated) cnt_trunc++;
    end
  end

  // Reference model state: the bytes of the most recent good frame and when it landed.
  logic [7:0]   frm  [31];
  logic [7:0]   good [31];
  logic         has_good = 1'b0;
  int           good_cyc = 0;

  // Observations from the latest run_frame.
  logic         o_upd_n1, o_upd_n2, o_valid;
  logic [101:0] o_fields;
  int           o_cyc;
  logic [31:0]  o_counts;

  function automatic logic [101:0] dut_fields();
    return {video_format, active_format_info_present, bar_info, scan_info,
            colorimetry, picture_aspect_ratio, active_format_aspect_ratio,
            it_content, extended_colorimetry, rgb_quantization_range, non_uniform_picture_scaling,
            video_id_code, ycc_quantization_range, content_type, pixel_repetition,
            bar_top_end, bar_bottom_start, bar_left_end, bar_right_start};
  endfunction

  function automatic logic [101:0] exp_fields();
    logic [7:0]  p1, p2, p3, p4, p5;
    logic [15:0] bt, bb, bl, br;
    p1 = good[4]; p2 = good[5]; p3 = good[6]; p4 = good[7]; p5 = good[8];
    bt = 16'(good[10]) * 16'd256 + 16'(good[9]);
    bb = 16'(good[12]) * 16'd256 + 16'(good[11]);
    bl = 16'(good[14]) * 16'd256 + 16'(good[13]);
    br = 16'(good[16]) * 16'd256 + 16'(good[15]);
    return {2'(p1 / 32), 1'(p1 / 16), 2'(p1 / 4), 2'(p1),
            2'(p2 / 64), 2'(p2 / 16), 4'(p2),
            1'(p3 / 128), 3'(p3 / 16), 2'(p3 / 4), 2'(p3),
            7'(p4), 2'(p5 / 64), 2'(p5 / 16), 4'(p5),
            bt, bb, bl, br};
  endfunction

  // 0 = ignored, 1 = format error, 2 = checksum error, 3 = accepted
  function automatic int classify();
    int s = 0;
    if (frm[0] != 8'h82) return 0;
    if (frm[1] != 8'h02 || (frm[2] % 32) != 13) return 1;
    for (int i = 0; i <= 16; i++) s += int'(frm[i]);
    if (s % 256 != 0) return 2;
    return 3;
  endfunction

  function automatic logic exp_valid();
    return has_good && ((o_cyc - good_cyc) < TIMEOUT);
  endfunction

  function automatic logic [31:0] exp_counts(input int kind, input int trunc);
    return {8'(kind == 3), 8'(kind == 1), 8'(kind == 2), 8'(trunc)};
  endfunction

  task automatic model_accept(input int kind);
    if (kind == 3) begin
      for (int i = 0; i < 31; i++) good[i] = frm[i];
      has_good = 1'b1;
      good_cyc = o_cyc;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 31; i++) good[i] = 8'h00;
    has_good = 1'b0;
  endtask

  task automatic fix_sum();
    int s = 0;
    frm[3] = 8'h00;
    for (int i = 0; i <= 16; i++) s += int'(frm[i]);
    frm[3] = 8'((256 - s % 256) % 256);
  endtask

  task automatic make_good();
    for (int i = 0; i < 31; i++) frm[i] = 8'($urandom);
    frm[0] = 8'h82;
    frm[1] = 8'h02;
    frm[2] = 8'($urandom_range(0, 7) * 32 + 13);
    fix_sum();
  endtask

  task automatic make_zero();
    for (int i = 0; i < 31; i++) frm[i] = 8'h00;
    frm[0] = 8'h82; frm[1] = 8'h02; frm[2] = 8'h0D;
  endtask

  task automatic drive(input logic [7:0] b, input logic st);
    byte_valid = 1'b1; packet_start = st; byte_in = b;
    @(posedge clk_pixel); #1;
    byte_valid = 1'b0; packet_start = 1'b0; byte_in = 8'($urandom);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      packet_start = 1'($urandom); byte_valid = 1'($urandom); byte_in = 8'($urandom);
      @(posedge clk_pixel); #1;
    end
    reset = 1'b0; byte_valid = 1'b0; packet_start = 1'b0;
    model_reset();
  endtask

  task automatic run_frame(input int prefix, input int stall_at, input int stall_len);
    int s_u, s_f, s_c, s_t;
    s_u = cnt_upd; s_f = cnt_fmt; s_c = cnt_csum; s_t = cnt_trunc;
    for (int i = 0; i < prefix; i++) drive(8'($urandom), i == 0);
    for (int i = 0; i < 31; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          packet_start = 1'($urandom); byte_in = 8'($urandom);
          @(posedge clk_pixel); #1;
          packet_start = 1'b0;
        end
      end
      drive(frm[i], i == 0);
    end
    @(negedge clk_pixel); o_upd_n1 = frame_update;
    @(negedge clk_pixel); o_upd_n2 = frame_update;
    o_valid = info_valid; o_fields = dut_fields(); o_cyc = cyc;
    @(posedge clk_pixel); #1;
    o_counts = {8'(cnt_upd - s_u), 8'(cnt_fmt - s_f), 8'(cnt_csum - s_c), 8'(cnt_trunc - s_t)};
  endtask

  task automatic test_reset();
    do_reset(3);
    @(negedge clk_pixel);
    vectors++; if (info_valid !== 1'b0) begin miscompares++; $display("FAIL reset_info_valid: got %0b want 0", info_valid); end
    vectors++; if (dut_fields() !== 102'd0) begin miscompares++; $display("FAIL reset_fields: got %0h want 0", dut_fields()); end
    vectors++;
    if ({frame_update, error_format, error_checksum, error_truncated} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_pulses: got %b want 0000", {frame_update, error_format, error_checksum, error_truncated});
    end
    @(posedge clk_pixel); #1;
  endtask

  task automatic test_good_frame();
    int kind;
    make_zero(); frm[3] = 8'h57; frm[5] = 8'h08; frm[7] = 8'h10;
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (o_upd_n1 !== 1'b0) begin miscompares++; $display("FAIL good_update_n1: got %0b want 0", o_upd_n1); end
    vectors++; if (o_upd_n2 !== 1'b1) begin miscompares++; $display("FAIL good_update_n2: got %0b want 1", o_upd_n2); end
    vectors++; if (video_id_code !== 7'd16) begin miscompares++; $display("FAIL good_vic: got %0d want 16", video_id_code); end
    vectors++; if (active_format_aspect_ratio !== 4'b1000) begin miscompares++; $display("FAIL good_afar: got %b want 1000", active_format_aspect_ratio); end
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL good_info_valid: got %0b want 1", o_valid); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL good_fields: got %0h want %0h", o_fields, exp_fields()); end
    vectors++; if (o_counts !== exp_counts(3, 0)) begin miscompares++; $display("FAIL good_pulses: got %h want %h", o_counts, exp_counts(3, 0)); end
  endtask

  task automatic test_checksum_fault();
    int kind;
    make_zero(); frm[3] = 8'h58; frm[5] = 8'h08; frm[7] = 8'h10;
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(2, 0)) begin miscompares++; $display("FAIL csum_pulses: got %h want %h", o_counts, exp_counts(2, 0)); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL csum_fields_kept: got %0h want %0h", o_fields, exp_fields()); end
    vectors++; if (o_valid !== exp_valid()) begin miscompares++; $display("FAIL csum_info_valid: got %0b want %0b", o_valid, exp_valid()); end
  endtask

  task automatic test_format();
    int kind;
    make_good(); frm[1] = 8'h03;
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(1, 0)) begin miscompares++; $display("FAIL format_hb1_pulses: got %h want %h", o_counts, exp_counts(1, 0)); end
    make_good(); frm[0] = 8'h83;
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(0, 0)) begin miscompares++; $display("FAIL type_silent_pulses: got %h want %h", o_counts, exp_counts(0, 0)); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL type_fields_kept: got %0h want %0h", o_fields, exp_fields()); end
  endtask

  task automatic test_stall_restart();
    int kind;
    make_good();
    kind = classify();
    run_frame(0, 12, 5);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(3, 0)) begin miscompares++; $display("FAIL stall_pulses: got %h want %h", o_counts, exp_counts(3, 0)); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL stall_fields: got %0h want %0h", o_fields, exp_fields()); end
    make_good();
    kind = classify();
    run_frame(12, -1, 0);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(3, 1)) begin miscompares++; $display("FAIL restart_pulses: got %h want %h", o_counts, exp_counts(3, 1)); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL restart_fields: got %0h want %0h", o_fields, exp_fields()); end
  endtask

  task automatic test_bars_timeout();
    int kind;
    make_zero(); frm[4] = 8'h0C; frm[9] = 8'h2C; frm[10] = 8'h01; fix_sum();
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (bar_top_end !== 16'h012C) begin miscompares++; $display("FAIL bar_top_end: got %h want 012c", bar_top_end); end
    vectors++; if (bar_info !== 2'b11) begin miscompares++; $display("FAIL bar_info: got %b want 11", bar_info); end
    while (info_valid === 1'b1 && (cyc - o_cyc) < 3 * TIMEOUT) @(negedge clk_pixel);
    vectors++; if (cyc - o_cyc !== TIMEOUT) begin miscompares++; $display("FAIL stale_timeout: got %0d cycles want %0d", cyc - o_cyc, TIMEOUT); end
    vectors++; if (dut_fields() !== exp_fields()) begin miscompares++; $display("FAIL stale_fields_kept: got %0h want %0h", dut_fields(), exp_fields()); end
    @(posedge clk_pixel); #1;
  endtask

  task automatic test_reset_mid_packet();
    int kind;
    make_good();
    for (int i = 0; i < 20; i++) drive(frm[i], i == 0);
    do_reset(2);
    @(negedge clk_pixel);
    vectors++; if (info_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_info_valid: got %0b want 0", info_valid); end
    @(posedge clk_pixel); #1;
    make_good();
    kind = classify();
    run_frame(0, -1, 0);
    model_accept(kind);
    vectors++; if (o_counts !== exp_counts(3, 0)) begin miscompares++; $display("FAIL midreset_pulses: got %h want %h", o_counts, exp_counts(3, 0)); end
    vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL midreset_fields: got %0h want %0h", o_fields, exp_fields()); end
  endtask

  task automatic test_random();
    int kind, prefix, stall_at, stall_len, sel;
    for (int n = 0; n < 40; n++) begin
      make_good();
      sel = $urandom_range(0, 9);
      if (sel == 0) frm[0] = 8'h82 ^ 8'($urandom_range(1, 255));
      if (sel == 1) frm[1] = 8'h02 ^ 8'($urandom_range(1, 255));
      if (sel == 2) frm[2] = frm[2] ^ 8'($urandom_range(1, 31));
      if (sel == 3) frm[3] = frm[3] ^ 8'($urandom_range(1, 255));
      kind   = classify();
      prefix = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      stall_at  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 30) : -1;
      stall_len = $urandom_range(1, 6);
      repeat ($urandom_range(0, 2)) drive(8'($urandom), 1'b0);
      run_frame(prefix, stall_at, stall_len);
      model_accept(kind);
      vectors++;
      if (o_counts !== exp_counts(kind, (prefix > 0) ? 1 : 0)) begin
        miscompares++; $display("FAIL rand%0d_pulses: got %h want %h", n, o_counts, exp_counts(kind, (prefix > 0) ? 1 : 0));
      end
      vectors++; if (o_upd_n1 !== 1'b0) begin miscompares++; $display("FAIL rand%0d_early_update: got %0b want 0", n, o_upd_n1); end
      vectors++; if (o_valid !== exp_valid()) begin miscompares++; $display("FAIL rand%0d_info_valid: got %0b want %0b", n, o_valid, exp_valid()); end
      vectors++; if (o_fields !== exp_fields()) begin miscompares++; $display("FAIL rand%0d_fields: got %0h want %0h", n, o_fields, exp_fields()); end
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(30, 110)) @(posedge clk_pixel);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_checksum_fault();
    test_format();
    test_stall_restart();
    test_bars_timeout();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
